// File: rtl/sweep_ctrl_if.sv
// Sweep sequencer control/generator bundle.
// master: control side, slave: sweep_ctrl.
interface sweep_ctrl_if #(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 8,
    parameter int C_WIDTH = 16
);
    logic               start;
    logic               stop_req;
    logic               pause;
    logic [A_WIDTH-1:0] incr_start;
    logic [A_WIDTH-1:0] incr_stop;
    logic [A_WIDTH-1:0] incr_step;
    logic [C_WIDTH-1:0] div;
    logic [C_WIDTH-1:0] dwell;
    logic [D_WIDTH-1:0] offset_in;
    logic               en;
    logic [A_WIDTH-1:0] incr;
    logic [D_WIDTH-1:0] offset;
    logic               busy;
    logic               done;
    logic               dir;

    modport master (
        output start, stop_req, pause,
        output incr_start, incr_stop, incr_step,
        output div, dwell, offset_in,
        input  en, incr, offset, busy, done, dir
    );

    modport slave (
        input  start, stop_req, pause,
        input  incr_start, incr_stop, incr_step,
        input  div, dwell, offset_in,
        output en, incr, offset, busy, done, dir
    );
endinterface

// File: rtl/sweep_ctrl.sv
// Frequency-sweep sequencer driving the sine generator en/incr/offset.
// Optional SWEEP_PINGPONG_EN: bounce between incr_start and incr_stop.
module sweep_ctrl #(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 8,
    parameter int C_WIDTH = 16
) (
    input logic       clk,
    input logic       rst,
    sweep_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE, S_RUN, S_PAUSE, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] incr_q, incr_d;
    logic [D_WIDTH-1:0] offset_q, offset_d;
    logic [A_WIDTH-1:0] stop_q, stop_d;
    logic [A_WIDTH-1:0] step_q, step_d;
    logic [C_WIDTH-1:0] div_q, div_d;
    logic [C_WIDTH-1:0] dwell_q, dwell_d;
    logic [C_WIDTH-1:0] pcnt_q, pcnt_d;
    logic [C_WIDTH-1:0] dcnt_q, dcnt_d;
    logic               last_q, last_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [A_WIDTH:0]   sum;
`ifdef SWEEP_PINGPONG_EN
    logic [A_WIDTH-1:0] start_q, start_d;
    logic               dir_q, dir_d;
    logic [A_WIDTH:0]   diff;
`endif

    // next-state, counters and step arithmetic
    always_comb begin
        state_d  = state_q;
        incr_d   = incr_q;
        offset_d = offset_q;
        stop_d   = stop_q;
        step_d   = step_q;
        div_d    = div_q;
        dwell_d  = dwell_q;
        pcnt_d   = pcnt_q;
        dcnt_d   = dcnt_q;
        last_d   = last_q;
`ifdef SWEEP_PINGPONG_EN
        start_d  = start_q;
        dir_d    = dir_q;
        diff     = {1'b0, incr_q} - {1'b0, step_q};
`endif
        sum = {1'b0, incr_q} + {1'b0, step_q};
        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop_req) begin
                    incr_d   = bus.incr_start;
                    offset_d = bus.offset_in;
                    stop_d   = bus.incr_stop;
                    step_d   = bus.incr_step;
                    div_d    = bus.div;
                    dwell_d  = bus.dwell;
                    pcnt_d   = '0;
                    dcnt_d   = '0;
                    last_d   = (bus.incr_step == '0) ||
                               (bus.incr_start >= bus.incr_stop);
`ifdef SWEEP_PINGPONG_EN
                    start_d  = bus.incr_start;
                    dir_d    = 1'b0;
`endif
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.stop_req) begin
                    state_d = S_IDLE;
                end else begin
                    if (en_q) begin
                        pcnt_d = '0;
                        if (dcnt_q == dwell_q) begin
                            dcnt_d = '0;
                            if (last_q) begin
                                state_d = S_DONE;
                            end else begin
`ifdef SWEEP_PINGPONG_EN
                                if (!dir_q) begin
                                    if (sum >= {1'b0, stop_q}) begin
                                        incr_d = stop_q;
                                        dir_d  = 1'b1;
                                    end else begin
                                        incr_d = sum[A_WIDTH-1:0];
                                    end
                                end else begin
                                    if (diff[A_WIDTH] ||
                                        diff[A_WIDTH-1:0] <= start_q) begin
                                        incr_d = start_q;
                                        dir_d  = 1'b0;
                                    end else begin
                                        incr_d = diff[A_WIDTH-1:0];
                                    end
                                end
`else
                                if (sum >= {1'b0, stop_q}) begin
                                    incr_d = stop_q;
                                    last_d = 1'b1;
                                end else begin
                                    incr_d = sum[A_WIDTH-1:0];
                                end
`endif
                            end
                        end else begin
                            dcnt_d = dcnt_q + C_WIDTH'(1);
                        end
                    end else begin
                        pcnt_d = pcnt_q + C_WIDTH'(1);
                    end
                    if (state_d != S_DONE && bus.pause) begin
                        state_d = S_PAUSE;
                    end
                end
            end
            S_PAUSE: begin
                if (bus.stop_req) begin
                    state_d = S_IDLE;
                end else if (!bus.pause) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        en_d   = (state_d == S_RUN) && (pcnt_d == div_d);
        busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
        done_d = (state_d == S_DONE);
    end

    // state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            incr_q   <= '0;
            offset_q <= '0;
            stop_q   <= '0;
            step_q   <= '0;
            div_q    <= '0;
            dwell_q  <= '0;
            pcnt_q   <= '0;
            dcnt_q   <= '0;
            last_q   <= 1'b0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            incr_q   <= incr_d;
            offset_q <= offset_d;
            stop_q   <= stop_d;
            step_q   <= step_d;
            div_q    <= div_d;
            dwell_q  <= dwell_d;
            pcnt_q   <= pcnt_d;
            dcnt_q   <= dcnt_d;
            last_q   <= last_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef SWEEP_PINGPONG_EN
    // bounce-mode lower bound and direction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= '0;
            dir_q   <= 1'b0;
        end else begin
            start_q <= start_d;
            dir_q   <= dir_d;
        end
    end

    assign bus.dir = dir_q;
`else
    assign bus.dir = 1'b0;
`endif

    assign bus.en     = en_q;
    assign bus.incr   = incr_q;
    assign bus.offset = offset_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_sweep_ctrl.sv
// Self-checking bench for sweep_ctrl: directed and randomized sweeps
// against a step-list reference model.
module tb_sweep_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic pause_e;
    logic stop_e;

    always #5 clk = ~clk;

    sweep_ctrl_if bus ();

    sweep_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        pause_e = bus.pause;
        stop_e  = bus.stop_req;
        #1;
    endtask

    task automatic idle_inputs();
        bus.start    = 1'b0;
        bus.stop_req = 1'b0;
        bus.pause    = 1'b0;
    endtask

    task automatic rand_inputs();
        bus.start      = 1'($urandom);
        bus.incr_start = 8'($urandom);
        bus.incr_stop  = 8'($urandom);
        bus.incr_step  = 8'($urandom);
        bus.div        = 16'($urandom);
        bus.dwell      = 16'($urandom);
        bus.offset_in  = 8'($urandom);
    endtask

    task automatic load(input int s, input int e, input int st,
                        input int dv, input int dw, input int off);
        bus.incr_start = 8'(s);
        bus.incr_stop  = 8'(e);
        bus.incr_step  = 8'(st);
        bus.div        = 16'(dv);
        bus.dwell      = 16'(dw);
        bus.offset_in  = 8'(off);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_en"}, bus.en, 0);
        chk({tag, "_done"}, bus.done, 0);
    endtask

    // One single sweep; the model is the list of increments the generator
    // must see, one entry per en pulse.
    task automatic run_sweep(input int s, input int e, input int st,
                             input int dv, input int dw, input int off,
                             input int p_at, input int p_len,
                             input int ab_at, input bit ab_p);
        int q[$];
        int v;
        int act;
        int last_incr;
        bit done_nx;
        bit ended;
        bit exp_en;
        v = s;
        forever begin
            for (int k = 0; k <= dw; k++) q.push_back(v);
            if (st == 0 || v >= e) break;
            v = (v + st >= e) ? e : v + st;
        end
        load(s, e, st, dv, dw, off);
        idle_inputs();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        act = 0;
        done_nx = 1'b0;
        ended = 1'b0;
        last_incr = s;
        for (int cyc = 1; cyc < 20000; cyc++) begin
            if (done_nx) begin
                chk("done", bus.done, 1);
                chk("done_busy", bus.busy, 0);
                chk("done_en", bus.en, 0);
                chk("done_incr", bus.incr, last_incr);
                ended = 1'b1;
                break;
            end
            if (stop_e) begin
                chk("abort_busy", bus.busy, 0);
                chk("abort_en", bus.en, 0);
                chk("abort_done", bus.done, 0);
                chk("abort_incr", bus.incr, last_incr);
                ended = 1'b1;
                break;
            end
            chk("busy", bus.busy, 1);
            chk("done_low", bus.done, 0);
            chk("offset", bus.offset, off);
            chk("dir", bus.dir, 0);
            chk("incr", bus.incr, q[0]);
            last_incr = q[0];
            exp_en = 1'b0;
            if (!pause_e) begin
                act++;
                exp_en = (act % (dv + 1)) == 0;
            end
            chk("en", bus.en, exp_en);
            if (exp_en) begin
                void'(q.pop_front());
                if (q.size() == 0) done_nx = 1'b1;
            end
            rand_inputs();
            bus.pause    = (cyc >= p_at) && (cyc < p_at + p_len);
            bus.stop_req = (cyc == ab_at) && !done_nx;
            if (ab_p && bus.stop_req) bus.pause = 1'b1;
            tick();
        end
        if (!ended) chk("timeout", 0, 1);
        idle_inputs();
        tick();
        check_idle("post");
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        load(0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_en", bus.en, 0);
        chk("rst_incr", bus.incr, 0);
        chk("rst_offset", bus.offset, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_dir", bus.dir, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_idle("idle");

        // start together with stop_req stays idle
        load(4, 16, 4, 0, 0, 1);
        bus.start = 1'b1;
        bus.stop_req = 1'b1;
        tick();
        idle_inputs();
        check_idle("start_stop");
        tick();
        check_idle("start_stop2");

        // asynchronous reset in the middle of a sweep
        begin
            bit seen;
            seen = 1'b0;
            load(4, 16, 4, 0, 1, 8'h3c);
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            for (int i = 0; i < 50; i++) begin
                if (bus.incr == 8'd12) begin
                    seen = 1'b1;
                    break;
                end
                tick();
            end
            chk("reach12", seen, 1);
            #2;
            rst = 1'b1;
            #1;
            chk("arst_en", bus.en, 0);
            chk("arst_incr", bus.incr, 0);
            chk("arst_offset", bus.offset, 0);
            chk("arst_busy", bus.busy, 0);
            chk("arst_done", bus.done, 0);
            chk("arst_dir", bus.dir, 0);
            @(negedge clk);
            rst = 1'b0;
            tick();
            check_idle("arst_idle");
        end

`ifdef SWEEP_PINGPONG_EN
        begin
            int  v;
            bit  d;
            int  pulses;
            int  nv;
            load(2, 8, 3, 0, 0, 9);
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            v = 2;
            d = 1'b0;
            pulses = 0;
            for (int cyc = 0; cyc < 200 && pulses < 9; cyc++) begin
                chk("pp_busy", bus.busy, 1);
                chk("pp_done", bus.done, 0);
                if (bus.en) begin
                    chk("pp_incr", bus.incr, v);
                    chk("pp_dir", bus.dir, d);
                    pulses++;
                    if (!d) begin
                        nv = v + 3;
                        if (nv >= 8) begin
                            nv = 8;
                            d = 1'b1;
                        end
                    end else begin
                        nv = v - 3;
                        if (nv <= 2) begin
                            nv = 2;
                            d = 1'b0;
                        end
                    end
                    v = nv;
                end
                tick();
            end
            chk("pp_pulses", pulses, 9);
            bus.stop_req = 1'b1;
            tick();
            idle_inputs();
            check_idle("pp_stop");
        end
`else
        run_sweep(4, 16, 4, 0, 1, 8'h55, 0, 0, -1, 1'b0);
        run_sweep(10, 15, 4, 2, 0, 8'h21, 0, 0, -1, 1'b0);
        run_sweep(4, 16, 4, 0, 1, 8'h10, 3, 5, -1, 1'b0);
        run_sweep(4, 16, 4, 1, 1, 8'h11, 4, 3, 6, 1'b1);
        run_sweep(7, 20, 0, 1, 2, 8'h07, 0, 0, -1, 1'b0);
        run_sweep(30, 20, 5, 0, 0, 8'h02, 0, 0, -1, 1'b0);
        run_sweep(200, 250, 100, 0, 0, 8'hf0, 0, 0, -1, 1'b0);
        run_sweep(3, 40, 9, 3, 0, 8'h44, 0, 0, 9, 1'b0);
        for (int n = 0; n < 25; n++) begin
            int s;
            int e;
            int st;
            int ab;
            s  = int'($urandom % 256);
            e  = ($urandom % 4 == 0) ? int'($urandom % 256)
                                     : s + int'($urandom % (256 - s));
            st = ($urandom % 6 == 0) ? 0 : 4 + int'($urandom % 100);
            ab = ($urandom % 4 == 0) ? 1 + int'($urandom % 60) : -1;
            run_sweep(s, e, st, int'($urandom % 4), int'($urandom % 3),
                      int'($urandom % 256), 1 + int'($urandom % 100),
                      int'($urandom % 7), ab, 1'($urandom));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
